// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared widths, divisor type and special divisor codes for the clock divider
package clk_div_pkg;

    localparam int DIV_W_DEFAULT = 8;

    typedef logic [DIV_W_DEFAULT-1:0] div_t;

    // Divisor codes below 2 do not count: 0 parks the channel, 1 passes every cycle through
    localparam int DIV_STOP   = 0;
    localparam int DIV_BYPASS = 1;

endpackage

// File: rtl/clk_div_channel.sv
// rtl/clk_div_channel.sv - one divider channel: period counter, active/pending divisor, registered outputs
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEFAULT,
    parameter int RESET_DIV = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sync_i,
    input  logic             div_load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             div_clk_o,
    output logic             tick_o,
    output logic             pend_o
);

    localparam logic [DIV_W-1:0] ONE  = DIV_W'(DIV_BYPASS);
    localparam logic [DIV_W-1:0] STOP = DIV_W'(DIV_STOP);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] nxt_div_q, nxt_div_d;
    logic             pend_q, pend_d;
    logic             div_clk_q, div_clk_d;
    logic             tick_q, tick_d;
    logic             running;
    logic             last;
    logic             apply;

    always_comb begin
        running   = cur_div_q > ONE;
        last      = running && (cnt_q == cur_div_q - ONE);
        // Channels that are stopped or bypassed sit on a boundary every cycle
        apply     = pend_q && (!running || last || sync_i);
        cnt_d     = (apply || sync_i || !running || last) ? '0 : cnt_q + ONE;
        cur_div_d = apply ? nxt_div_q : cur_div_q;
        // A load coinciding with an apply becomes pending for the following boundary
        nxt_div_d = div_load_i ? div_i : nxt_div_q;
        pend_d    = div_load_i ? 1'b1 : (apply ? 1'b0 : pend_q);
        div_clk_d = 1'b0;
        tick_d    = 1'b0;
        if (sync_i) begin
            div_clk_d = 1'b0;
            tick_d    = 1'b0;
        end else if (running) begin
            div_clk_d = cnt_q < (cur_div_q >> 1);
            tick_d    = cnt_q == STOP;
        end else if (cur_div_q == ONE) begin
            div_clk_d = 1'b1;
            tick_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            cur_div_q <= DIV_W'(RESET_DIV);
            nxt_div_q <= '0;
            pend_q    <= 1'b0;
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            nxt_div_q <= nxt_div_d;
            pend_q    <= pend_d;
            div_clk_q <= div_clk_d;
            tick_q    <= tick_d;
        end
    end

    assign div_clk_o = div_clk_q;
    assign tick_o    = tick_q;
    assign pend_o    = pend_q;

endmodule

// File: rtl/multi_channel_clock_divider.sv
// rtl/multi_channel_clock_divider.sv - NUM_CH independent clock dividers; CLK_DIV_SYNC_EN adds sync_i phase realignment
module multi_channel_clock_divider
    import clk_div_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = DIV_W_DEFAULT,
    parameter int RESET_DIV = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
`ifdef CLK_DIV_SYNC_EN
    input  logic                    sync_i,
`endif
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic [NUM_CH-1:0]       div_load_i,
    output logic [NUM_CH-1:0]       div_clk_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       pend_o
);

    logic sync_w;

`ifdef CLK_DIV_SYNC_EN
    assign sync_w = sync_i;
`else
    assign sync_w = 1'b0;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clk_div_channel #(
            .DIV_W     (DIV_W),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .sync_i     (sync_w),
            .div_load_i (div_load_i[c]),
            .div_i      (div_i[c*DIV_W +: DIV_W]),
            .div_clk_o  (div_clk_o[c]),
            .tick_o     (tick_o[c]),
            .pend_o     (pend_o[c])
        );
    end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// tb/tb_multi_channel_clock_divider.sv - directed and random stimulus against a phase-arithmetic reference model
module tb_multi_channel_clock_divider;

    localparam int NUM_CH    = 4;
    localparam int DIV_W     = 8;
    localparam int RESET_DIV = 4;

    logic                    clk_i = 1'b0;
    logic                    rst_i = 1'b1;
    logic                    sync_i = 1'b0;
    logic [NUM_CH*DIV_W-1:0] div_i = '0;
    logic [NUM_CH-1:0]       div_load_i = '0;
    logic [NUM_CH-1:0]       div_clk_o;
    logic [NUM_CH-1:0]       tick_o;
    logic [NUM_CH-1:0]       pend_o;

    int checks = 0;
    int errors = 0;

    // Model: a channel's phase is (edge index - period start) mod divisor
    int  m_t;
    int  m_cur[NUM_CH];
    int  m_nxt[NUM_CH];
    bit  m_pend[NUM_CH];
    int  m_t0[NUM_CH];
    bit  m_clk[NUM_CH];
    bit  m_tick[NUM_CH];

    always #5 clk_i = ~clk_i;

    multi_channel_clock_divider #(
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W),
        .RESET_DIV (RESET_DIV)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
`ifdef CLK_DIV_SYNC_EN
        .sync_i     (sync_i),
`endif
        .div_i      (div_i),
        .div_load_i (div_load_i),
        .div_clk_o  (div_clk_o),
        .tick_o     (tick_o),
        .pend_o     (pend_o)
    );

    task automatic model_edge(input bit rst, input bit sync, input logic [NUM_CH-1:0] ld,
                              input logic [NUM_CH*DIV_W-1:0] dv);
        for (int c = 0; c < NUM_CH; c++) begin
            int  ph;
            bit  bnd;
            if (rst) begin
                m_cur[c]  = RESET_DIV;
                m_pend[c] = 1'b0;
                m_t0[c]   = m_t + 1;
                m_clk[c]  = 1'b0;
                m_tick[c] = 1'b0;
            end else begin
                ph  = (m_cur[c] >= 2) ? (m_t - m_t0[c]) % m_cur[c] : 0;
                bnd = (m_cur[c] < 2) || (ph == m_cur[c] - 1) || sync;
                if (sync) begin
                    m_clk[c]  = 1'b0;
                    m_tick[c] = 1'b0;
                    m_t0[c]   = m_t + 1;
                end else begin
                    m_clk[c]  = (m_cur[c] == 1) || (m_cur[c] >= 2 && ph < m_cur[c] / 2);
                    m_tick[c] = (m_cur[c] == 1) || (m_cur[c] >= 2 && ph == 0);
                end
                if (m_pend[c] && bnd) begin
                    m_cur[c]  = m_nxt[c];
                    m_pend[c] = 1'b0;
                    m_t0[c]   = m_t + 1;
                end
                if (ld[c]) begin
                    m_nxt[c]  = int'(dv[c*DIV_W +: DIV_W]);
                    m_pend[c] = 1'b1;
                end
            end
        end
        m_t++;
    endtask

    task automatic check_outputs(input string tag);
        logic [NUM_CH-1:0] e_clk, e_tick, e_pend;
        for (int c = 0; c < NUM_CH; c++) begin
            e_clk[c]  = m_clk[c];
            e_tick[c] = m_tick[c];
            e_pend[c] = m_pend[c];
        end
        checks++;
        assert (div_clk_o === e_clk) else begin
            errors++;
            $error("FAIL %s div_clk_o observed %b expected %b (t=%0d)", tag, div_clk_o, e_clk, m_t);
        end
        checks++;
        assert (tick_o === e_tick) else begin
            errors++;
            $error("FAIL %s tick_o observed %b expected %b (t=%0d)", tag, tick_o, e_tick, m_t);
        end
        checks++;
        assert (pend_o === e_pend) else begin
            errors++;
            $error("FAIL %s pend_o observed %b expected %b (t=%0d)", tag, pend_o, e_pend, m_t);
        end
    endtask

    task automatic step(input string tag, input bit rst, input bit sync,
                        input logic [NUM_CH-1:0] ld, input logic [NUM_CH*DIV_W-1:0] dv);
        rst_i      = rst;
        sync_i     = sync;
        div_load_i = ld;
        div_i      = dv;
        @(posedge clk_i);
        model_edge(rst, sync, ld, dv);
        #1;
        check_outputs(tag);
    endtask

    task automatic expect_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_CH*DIV_W-1:0] one_div(input int ch, input int val);
        logic [NUM_CH*DIV_W-1:0] v;
        v = '0;
        v[ch*DIV_W +: DIV_W] = DIV_W'(val);
        return v;
    endfunction

    initial begin
        logic [7:0] clk_pat;
        logic [7:0] tick_pat;
        logic [NUM_CH-1:0]       rld;
        logic [NUM_CH*DIV_W-1:0] rdv;

        clk_pat  = 8'b00110011;
        tick_pat = 8'b00010001;
        m_t = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_cur[c] = RESET_DIV; m_nxt[c] = 0; m_pend[c] = 0;
            m_t0[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
        end

        for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b0, '0, '0);

        // Release: bits read LSB-first give 1,1,0,0,1,1,0,0 after the release edge
        for (int k = 0; k < 8; k++) begin
            step("release", 1'b0, 1'b0, '0, '0);
            expect_bit("release_clk0", div_clk_o[0], clk_pat[k]);
            expect_bit("release_tick3", tick_o[3], tick_pat[k]);
        end

        // cnt is now 0; one more edge puts ch0 mid-period at cnt=1 when the load is sampled
        step("pre_load", 1'b0, 1'b0, '0, '0);
        step("load5", 1'b0, 1'b0, 4'b0001, one_div(0, 5));
        expect_bit("load5_pend", pend_o[0], 1'b1);
        step("load5_wait", 1'b0, 1'b0, '0, '0);
        expect_bit("load5_still_pend", pend_o[0], 1'b1);
        step("load5_apply", 1'b0, 1'b0, '0, '0);
        expect_bit("load5_applied", pend_o[0], 1'b0);
        for (int i = 0; i < 12; i++) step("div5_run", 1'b0, 1'b0, '0, '0);

        // Stop then bypass on ch1
        step("load0", 1'b0, 1'b0, 4'b0010, one_div(1, 0));
        for (int i = 0; i < 6; i++) step("div0_run", 1'b0, 1'b0, '0, '0);
        expect_bit("stopped_clk1", div_clk_o[1], 1'b0);
        expect_bit("stopped_tick1", tick_o[1], 1'b0);
        step("load1", 1'b0, 1'b0, 4'b0010, one_div(1, 1));
        for (int i = 0; i < 4; i++) step("div1_run", 1'b0, 1'b0, '0, '0);
        expect_bit("bypass_clk1", div_clk_o[1], 1'b1);
        expect_bit("bypass_tick1", tick_o[1], 1'b1);

        // Last write wins on ch2
        step("load6", 1'b0, 1'b0, 4'b0100, one_div(2, 6));
        step("load7", 1'b0, 1'b0, 4'b0100, one_div(2, 7));
        for (int i = 0; i < 20; i++) step("div7_run", 1'b0, 1'b0, '0, '0);

        // Reset mid-period with a pending load discards it
        step("load_pre_rst", 1'b0, 1'b0, 4'b1000, one_div(3, 9));
        step("mid_rst", 1'b1, 1'b0, '0, '0);
        expect_bit("rst_pend3", pend_o[3], 1'b0);
        for (int i = 0; i < 9; i++) step("post_rst", 1'b0, 1'b0, '0, '0);

`ifdef CLK_DIV_SYNC_EN
        step("sync_ld", 1'b0, 1'b0, 4'b0011, one_div(0, 3) | one_div(1, 6));
        for (int i = 0; i < 11; i++) step("sync_free", 1'b0, 1'b0, '0, '0);
        step("sync_pulse", 1'b0, 1'b1, '0, '0);
        for (int i = 0; i < 14; i++) step("sync_run", 1'b0, 1'b0, '0, '0);
`endif

        // Random loads of small divisors with occasional reset
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rld[c] = ($urandom_range(0, 7) == 0);
                rdv[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 9));
            end
            step("random", ($urandom_range(0, 99) == 0), 1'b0, rld, rdv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
